conv_stream_master: RTL and testbench

Host-side counterpart to the 128x32 convolution engine: buffers one 128-sample input vector and one 32-tap filter, streams both to the engine over valid/ready master ports on `start`, and captures the 97 results into an internal result buffer. Sits between a host or testbench register interface and the convolution engine's slave x/f ports and master y port. One run per `start`; `done` signals completion.

---
 rtl/conv_stream_master.sv | 174 +++++++++++++++++
 tb/tb_conv_stream_master.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_stream_master.sv
// conv_stream_master: buffers a 128-sample vector and 32-tap filter, streams both to the
// convolution engine on start and captures the 97 results. Optional macro: CONV_MASTER_CHECKSUM_EN (adds y_sum).
`default_nettype none

module conv_stream_master #(
   parameter int DATA_N   = 128,
   parameter int FILTER_N = 32,
   parameter int Y_W      = 21
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        ld_we,
   input  logic                        ld_sel,
   input  logic [$clog2(DATA_N)-1:0]   ld_addr,
   input  logic [7:0]                  ld_data,
   input  logic                        start,
   output logic                        busy,
   output logic                        done,
   output logic                        m_valid_x,
   input  logic                        m_ready_x,
   output logic [7:0]                  m_data_x,
   output logic                        m_valid_f,
   input  logic                        m_ready_f,
   output logic [7:0]                  m_data_f,
   input  logic                        s_valid_y,
   output logic                        s_ready_y,
   input  logic [Y_W-1:0]              s_data_y,
   input  logic [$clog2(DATA_N)-1:0]   rd_addr,
   output logic [Y_W-1:0]              rd_data,
`ifdef CONV_MASTER_CHECKSUM_EN
   output logic [31:0]                 y_sum,
`endif
   output logic [$clog2(DATA_N)-1:0]   y_count
);

   localparam int CONV_N = DATA_N - FILTER_N + 1;
   localparam int AW     = $clog2(DATA_N);
   localparam int FW     = $clog2(FILTER_N);
   localparam logic [AW-1:0] X_LAST = AW'(DATA_N - 1);
   localparam logic [FW-1:0] F_LAST = FW'(FILTER_N - 1);
   localparam logic [AW-1:0] Y_LAST = AW'(CONV_N - 1);
   localparam logic [AW-1:0] Y_LIM  = AW'(CONV_N);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state_q;
   logic [7:0]         x_mem_q [DATA_N];
   logic [7:0]         f_mem_q [FILTER_N];
   logic [Y_W-1:0]     res_q   [CONV_N];
   logic [AW-1:0]      xk_q;
   logic [FW-1:0]      fk_q;
   logic [AW-1:0]      y_count_q;
   logic               busy_q, done_q;
   logic               m_valid_x_q, m_valid_f_q, s_ready_y_q;
   logic [7:0]         m_data_x_q, m_data_f_q;
   logic [Y_W-1:0]     rd_data_q;

   logic w_ld, w_x_hs, w_f_hs, w_y_hs, w_x_fin, w_f_fin, w_y_fin;

   assign w_ld    = (state_q == S_IDLE) && ld_we;
   assign w_x_hs  = m_valid_x_q && m_ready_x;
   assign w_f_hs  = m_valid_f_q && m_ready_f;
   assign w_y_hs  = s_ready_y_q && s_valid_y;
   // A stream counts as finished once its valid/ready has dropped or its last transfer happens now.
   assign w_x_fin = !m_valid_x_q || (m_ready_x && (xk_q == X_LAST));
   assign w_f_fin = !m_valid_f_q || (m_ready_f && (fk_q == F_LAST));
   assign w_y_fin = !s_ready_y_q || (s_valid_y && (y_count_q == Y_LAST));

   always_ff @(posedge clk) begin
      if (w_ld && !ld_sel) x_mem_q[ld_addr] <= ld_data;
      if (w_ld && ld_sel)  f_mem_q[ld_addr[FW-1:0]] <= ld_data;
      if (w_y_hs)          res_q[y_count_q] <= s_data_y;
   end

`ifdef CONV_MASTER_CHECKSUM_EN
   logic [31:0] y_sum_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         y_sum_q <= '0;
      end else if (state_q == S_IDLE && start) begin
         y_sum_q <= '0;
      end else if (state_q == S_RUN && w_y_hs) begin
         y_sum_q <= y_sum_q + {{(32-Y_W){s_data_y[Y_W-1]}}, s_data_y};
      end
   end

   assign y_sum = y_sum_q;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         xk_q        <= '0;
         fk_q        <= '0;
         y_count_q   <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         m_valid_x_q <= 1'b0;
         m_valid_f_q <= 1'b0;
         s_ready_y_q <= 1'b0;
         m_data_x_q  <= '0;
         m_data_f_q  <= '0;
         rd_data_q   <= '0;
      end else begin
         rd_data_q <= (rd_addr < Y_LIM) ? res_q[rd_addr] : '0;
         done_q    <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q     <= S_RUN;
                  busy_q      <= 1'b1;
                  xk_q        <= '0;
                  fk_q        <= '0;
                  y_count_q   <= '0;
                  m_valid_x_q <= 1'b1;
                  m_data_x_q  <= x_mem_q[0];
                  m_valid_f_q <= 1'b1;
                  m_data_f_q  <= f_mem_q[0];
                  s_ready_y_q <= 1'b1;
               end
            end
            S_RUN: begin
               if (w_x_hs) begin
                  if (xk_q == X_LAST) begin
                     m_valid_x_q <= 1'b0;
                  end else begin
                     xk_q       <= xk_q + 1'b1;
                     m_data_x_q <= x_mem_q[xk_q + 1'b1];
                  end
               end
               if (w_f_hs) begin
                  if (fk_q == F_LAST) begin
                     m_valid_f_q <= 1'b0;
                  end else begin
                     fk_q       <= fk_q + 1'b1;
                     m_data_f_q <= f_mem_q[fk_q + 1'b1];
                  end
               end
               if (w_y_hs) begin
                  y_count_q <= y_count_q + 1'b1;
                  if (y_count_q == Y_LAST) s_ready_y_q <= 1'b0;
               end
               if (w_x_fin && w_f_fin && w_y_fin) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign m_valid_x = m_valid_x_q;
   assign m_data_x  = m_data_x_q;
   assign m_valid_f = m_valid_f_q;
   assign m_data_f  = m_data_f_q;
   assign s_ready_y = s_ready_y_q;
   assign rd_data   = rd_data_q;
   assign y_count   = y_count_q;

endmodule

`default_nettype wire

// File: tb/tb_conv_stream_master.sv
// Self-checking bench for conv_stream_master: behavioural host/engine model plus literal pins.
`default_nettype none

module tb_conv_stream_master;

   localparam int DATA_N = 128;
   localparam int FILTER_N = 32;
   localparam int CONV_N = 97;
   localparam int Y_W = 21;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset, ld_we, ld_sel, start, busy, done;
   logic [6:0] ld_addr, rd_addr, y_count;
   logic [7:0] ld_data, m_data_x, m_data_f;
   logic m_valid_x, m_ready_x, m_valid_f, m_ready_f, s_valid_y, s_ready_y;
   logic [Y_W-1:0] s_data_y, rd_data;
`ifdef CONV_MASTER_CHECKSUM_EN
   logic [31:0] y_sum;
`endif

   conv_stream_master dut (
      .clk(clk), .reset(reset), .ld_we(ld_we), .ld_sel(ld_sel), .ld_addr(ld_addr),
      .ld_data(ld_data), .start(start), .busy(busy), .done(done),
      .m_valid_x(m_valid_x), .m_ready_x(m_ready_x), .m_data_x(m_data_x),
      .m_valid_f(m_valid_f), .m_ready_f(m_ready_f), .m_data_f(m_data_f),
      .s_valid_y(s_valid_y), .s_ready_y(s_ready_y), .s_data_y(s_data_y),
      .rd_addr(rd_addr), .rd_data(rd_data),
`ifdef CONV_MASTER_CHECKSUM_EN
      .y_sum(y_sum),
`endif
      .y_count(y_count)
   );

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
   endtask

   // Behavioural model: phase 0 idle, 1 streaming, 2 completion cycle.
   int ph, xs, fs, yc;
   logic [7:0] xm [DATA_N];
   logic [7:0] fm [FILTER_N];
   logic [Y_W-1:0] er [DATA_N];
   bit ek [DATA_N];
   logic [Y_W-1:0] exp_rd;
   bit rd_known;
   logic [31:0] esum;

   task automatic model_reset();
      ph = 0; xs = 0; fs = 0; yc = 0; exp_rd = '0; rd_known = 1; esum = '0;
   endtask

   task automatic model_update();
      if (!reset) return;
      rd_known = (rd_addr >= 7'(CONV_N)) || ek[rd_addr];
      exp_rd = (rd_addr >= 7'(CONV_N)) ? '0 : er[rd_addr];
      case (ph)
         0: begin
            if (ld_we) begin
               if (ld_sel) fm[ld_addr[4:0]] = ld_data;
               else xm[ld_addr] = ld_data;
            end
            if (start) begin
               ph = 1; xs = 0; fs = 0; yc = 0; esum = '0;
            end
         end
         1: begin
            if (xs < DATA_N && m_ready_x) xs++;
            if (fs < FILTER_N && m_ready_f) fs++;
            if (yc < CONV_N && s_valid_y) begin
               er[yc] = s_data_y; ek[yc] = 1;
               esum = esum + 32'($signed(s_data_y));
               yc++;
            end
            if (xs == DATA_N && fs == FILTER_N && yc == CONV_N) ph = 2;
         end
         default: ph = 0;
      endcase
   endtask

   function automatic int ref_conv(input int k);
      int s = 0;
      for (int j = 0; j < FILTER_N; j++) s += $signed(xm[k+j]) * $signed(fm[j]);
      return s;
   endfunction

   bit cmp_en = 0;
   always @(negedge clk) begin
      if (reset && cmp_en) begin
         chk("busy", busy, ph != 0);
         chk("done", done, ph == 2);
         chk("m_valid_x", m_valid_x, ph == 1 && xs < DATA_N);
         if (ph == 1 && xs < DATA_N) chk("m_data_x", m_data_x, xm[xs]);
         chk("m_valid_f", m_valid_f, ph == 1 && fs < FILTER_N);
         if (ph == 1 && fs < FILTER_N) chk("m_data_f", m_data_f, fm[fs]);
         chk("s_ready_y", s_ready_y, ph == 1 && yc < CONV_N);
         chk("y_count", y_count, yc);
         if (rd_known) chk("rd_data", rd_data, exp_rd);
`ifdef CONV_MASTER_CHECKSUM_EN
         chk("y_sum", y_sum, esum);
`endif
      end
   end

   // Engine side: records received streams and returns correlation results.
   logic [7:0] ex[$];
   logic [7:0] ef[$];
   int ey, xcyc, fcyc, dcnt;
   bit seen_done, stall_en = 0, pulse_en = 0, extra_y = 0, rd_manual = 0;

   function automatic logic [Y_W-1:0] eng_y(input int k);
      int s = 0;
      for (int j = 0; j < FILTER_N; j++) s += $signed(ex[k+j]) * $signed(ef[j]);
      return s[Y_W-1:0];
   endfunction

   task automatic drive();
      m_ready_x = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      m_ready_f = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (pulse_en && ph == 1) begin
         ld_we = 1'($urandom_range(0, 1)); ld_sel = 1'($urandom_range(0, 1));
         ld_addr = 7'($urandom); ld_data = 8'($urandom); start = 1'($urandom_range(0, 1));
      end else begin
         ld_we = 0; start = 0;
      end
      if (ey < CONV_N && ef.size() == FILTER_N && ex.size() >= ey + FILTER_N
          && (!stall_en || $urandom_range(0, 2) != 0)) begin
         s_valid_y = 1; s_data_y = eng_y(ey);
      end else if (extra_y && ey >= CONV_N) begin
         s_valid_y = 1; s_data_y = 21'h0ABCD;
      end else begin
         s_valid_y = 0;
      end
      if (!rd_manual) rd_addr = 7'($urandom_range(0, 127));
   endtask

   task automatic step();
      @(negedge clk);
      if (m_valid_x) xcyc++;
      if (m_valid_f) fcyc++;
      if (done) begin dcnt++; seen_done = 1; end
      if (m_valid_x && m_ready_x) ex.push_back(m_data_x);
      if (m_valid_f && m_ready_f) ef.push_back(m_data_f);
      if (s_valid_y && s_ready_y) ey++;
      @(posedge clk);
      model_update();
      #1;
      drive();
   endtask

   task automatic begin_run();
      ex.delete(); ef.delete(); ey = 0; xcyc = 0; fcyc = 0; dcnt = 0; seen_done = 0;
      start = 1;
   endtask

   task automatic run_once();
      begin_run();
      for (int c = 0; c < 4000 && !seen_done; c++) step();
      chk("run_completed", seen_done, 1);
      repeat (3) step();
   endtask

   task automatic load(input int mode);
      for (int i = 0; i < DATA_N; i++) begin
         ld_we = 1; ld_sel = 0; ld_addr = 7'(i);
         ld_data = (mode == 0) ? 8'd1 : (mode == 2) ? 8'h80 : 8'($urandom);
         step();
      end
      for (int j = 0; j < FILTER_N; j++) begin
         ld_we = 1; ld_sel = 1; ld_addr = 7'(j);
         ld_data = (mode == 0) ? 8'd1 : (mode == 2) ? 8'h7F : 8'($urandom);
         step();
      end
   endtask

   task automatic check_results();
      rd_manual = 1;
      for (int k = 0; k < DATA_N; k += (k < CONV_N + 2) ? 1 : 9) begin
         rd_addr = 7'(k);
         step();
         chk("result", longint'($signed(rd_data)), (k < CONV_N) ? ref_conv(k) : 0);
      end
      rd_manual = 0;
   endtask

   task automatic read_lit(input int a, input longint exp, input string nm);
      rd_manual = 1; rd_addr = 7'(a);
      step();
      chk(nm, longint'($signed(rd_data)), exp);
      rd_manual = 0;
   endtask

   initial begin
      reset = 0; ld_we = 0; ld_sel = 0; ld_addr = '0; ld_data = '0; start = 0;
      m_ready_x = 0; m_ready_f = 0; s_valid_y = 0; s_data_y = '0; rd_addr = '0;
      ey = 0;
      model_reset();
      #12;
      chk("rst_busy", busy, 0); chk("rst_done", done, 0);
      chk("rst_vx", m_valid_x, 0); chk("rst_vf", m_valid_f, 0); chk("rst_ry", s_ready_y, 0);
      chk("rst_dx", m_data_x, 0); chk("rst_df", m_data_f, 0);
      chk("rst_rd", rd_data, 0); chk("rst_ycnt", y_count, 0);
      step(); step();
      reset = 1; cmp_en = 1;

      // All-ones run with an extra 98th y offer after completion.
      load(0);
      extra_y = 1;
      run_once();
      chk("x_cycles", xcyc, 128); chk("f_cycles", fcyc, 32);
      chk("done_pulses", dcnt, 1); chk("y_count_end", y_count, 97);
      chk("ry_after_done", s_ready_y, 0);
      extra_y = 0;
      read_lit(0, 32, "res0_ones"); read_lit(96, 32, "res96_ones"); read_lit(97, 0, "res97_zero");
      chk("y_count_hold", y_count, 97);
      check_results();

      // Random data, stalls, and ignored ld_we/start during the run.
      load(1);
      stall_en = 1; pulse_en = 1;
      run_once();
      pulse_en = 0;
      chk("done_pulses_rand", dcnt, 1);
      check_results();

      // Asynchronous reset around x index 60, then rerun with retained buffers.
      begin_run();
      for (int c = 0; c < 2000 && ex.size() < 60; c++) step();
      chk("reached_x60", ex.size() >= 60, 1);
      #2; reset = 0; model_reset();
      #1;
      chk("mid_rst_vx", m_valid_x, 0); chk("mid_rst_vf", m_valid_f, 0);
      chk("mid_rst_ry", s_ready_y, 0); chk("mid_rst_busy", busy, 0);
      chk("mid_rst_ycnt", y_count, 0);
      step();
      reset = 1;
      run_once();
      chk("done_pulses_rerun", dcnt, 1);
      check_results();
      stall_en = 0;

`ifdef CONV_MASTER_CHECKSUM_EN
      load(2);
      run_once();
      read_lit(0, -520192, "res0_cks"); read_lit(50, -520192, "res50_cks");
      chk("y_sum_lit", longint'($signed(y_sum)), -50458624);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
